// File: rtl/seq_decimalizer_pkg.sv
// Shared types and helpers for the multi-channel serial binary-to-BCD converter.
package seq_decimalizer_pkg;

   typedef enum logic [1:0] {SD_IDLE, SD_SHIFT, SD_STORE, SD_COMMIT} sd_state_e;

   typedef logic [3:0] bcd_digit_t;

   // Upper bound on DIGITS supported by lz_mask_f.
   localparam int unsigned LZ_MAX_DIGITS = 16;

   // Digit d>0 is a leading zero when it and every higher in-range digit are zero.
   function automatic logic [LZ_MAX_DIGITS-1:0] lz_mask_f(
      input logic [LZ_MAX_DIGITS*4-1:0] bcd,
      input int unsigned                n_dig
   );
      logic [LZ_MAX_DIGITS-1:0] lz;
      logic                     all_zero;
      lz       = '0;
      all_zero = 1'b1;
      for (int d = LZ_MAX_DIGITS - 1; d >= 0; d--) begin
         if (d < int'(n_dig)) begin
            all_zero = all_zero & (bcd[d*4 +: 4] == 4'd0);
            if (d >= 1) lz[d] = all_zero;
         end
      end
      return lz;
   endfunction

endpackage

// File: rtl/seq_decimalizer_if.sv
// Request/result bundle between a client and seq_decimalizer.
interface seq_decimalizer_if #(
   parameter int unsigned N_CH   = 6,
   parameter int unsigned W_IN   = 8,
   parameter int unsigned DIGITS = 3
);
   logic                       start;
   logic                       continuous;
   logic [N_CH*W_IN-1:0]       values_in;
   logic                       busy;
   logic                       done;
   logic                       valid;
   logic [N_CH*DIGITS*4-1:0]   digits_out;
   logic [N_CH-1:0]            overflow;
   logic [N_CH*DIGITS-1:0]     lz_mask;

   modport master (
      output start, continuous, values_in,
      input  busy, done, valid, digits_out, overflow, lz_mask
   );

   modport slave (
      input  start, continuous, values_in,
      output busy, done, valid, digits_out, overflow, lz_mask
   );
endinterface

// File: rtl/seq_decimalizer_bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >=5, then shift one binary bit in.
module bcd_dabble_step
   import seq_decimalizer_pkg::*;
#(
   parameter int unsigned DIGITS = 3
) (
   input  logic [DIGITS*4-1:0] i_bcd,
   input  logic                i_bit,
   output logic [DIGITS*4-1:0] o_bcd,
   output logic                o_carry
);

   logic [DIGITS*4-1:0] w_adj;
   bcd_digit_t          w_dig;

   always_comb begin
      w_adj = '0;
      w_dig = '0;
      for (int d = 0; d < int'(DIGITS); d++) begin
         w_dig              = i_bcd[d*4 +: 4];
         w_adj[d*4 +: 4]    = (w_dig >= 4'd5) ? w_dig + 4'd3 : w_dig;
      end
      {o_carry, o_bcd} = {w_adj, i_bit};
   end

endmodule

// File: rtl/seq_decimalizer.sv
// Multi-channel serial binary-to-BCD converter; all channels are published together on commit.
module seq_decimalizer
   import seq_decimalizer_pkg::*;
#(
   parameter int unsigned N_CH   = 6,
   parameter int unsigned W_IN   = 8,
   parameter int unsigned DIGITS = 3
) (
   input logic              clk,
   input logic              rst_n,
   seq_decimalizer_if.slave io_bus
);

   localparam int unsigned CH_W  = $clog2(N_CH) + 1;
   localparam int unsigned BIT_W = $clog2(W_IN) + 1;
   localparam int unsigned BCD_W = DIGITS * 4;
   localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(W_IN - 1);
   localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'd9}};

   sd_state_e                r_state, w_state_nxt;
   logic [N_CH*W_IN-1:0]     r_snap;
   logic [W_IN-1:0]          r_bin;
   logic [BCD_W-1:0]         r_bcd;
   logic [BIT_W-1:0]         r_bit;
   logic [CH_W-1:0]          r_ch;
   logic                     r_ovf;
   logic [N_CH*BCD_W-1:0]    r_stage_dig;
   logic [N_CH-1:0]          r_stage_ovf;
   logic [N_CH*DIGITS-1:0]   r_stage_lz;
   logic [N_CH*BCD_W-1:0]    r_digits;
   logic [N_CH-1:0]          r_overflow;
   logic [N_CH*DIGITS-1:0]   r_lz;
   logic                     r_valid;

   logic [BCD_W-1:0]         w_step_bcd;
   logic                     w_step_carry;
   logic                     w_load;
   logic [BCD_W-1:0]         w_store_dig;
   logic [DIGITS-1:0]        w_store_lz;
   logic [LZ_MAX_DIGITS*4-1:0] w_lz_in;
   logic [W_IN-1:0]          w_next_val;

   bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
      .i_bcd   (r_bcd),
      .i_bit   (r_bin[W_IN-1]),
      .o_bcd   (w_step_bcd),
      .o_carry (w_step_carry)
   );

   assign w_load = ((r_state == SD_IDLE) && (io_bus.start || io_bus.continuous)) ||
                   ((r_state == SD_COMMIT) && io_bus.continuous);

   always_comb begin
      w_store_dig           = r_ovf ? ALL_NINES : r_bcd;
      w_lz_in               = '0;
      w_lz_in[BCD_W-1:0]    = w_store_dig;
      w_store_lz            = DIGITS'(lz_mask_f(w_lz_in, DIGITS));
      w_next_val            = '0;
      for (int c = 0; c < int'(N_CH); c++) begin
         if (int'(r_ch) + 1 == c) w_next_val = r_snap[c*W_IN +: W_IN];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SD_IDLE:   if (w_load) w_state_nxt = SD_SHIFT;
         SD_SHIFT:  if (r_bit == BIT_LAST) w_state_nxt = SD_STORE;
         SD_STORE:  w_state_nxt = (r_ch == CH_LAST) ? SD_COMMIT : SD_SHIFT;
         SD_COMMIT: w_state_nxt = io_bus.continuous ? SD_SHIFT : SD_IDLE;
         default:   w_state_nxt = SD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= SD_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snap      <= '0;
         r_bin       <= '0;
         r_bcd       <= '0;
         r_bit       <= '0;
         r_ch        <= '0;
         r_ovf       <= 1'b0;
         r_stage_dig <= '0;
         r_stage_ovf <= '0;
         r_stage_lz  <= '0;
         r_digits    <= '0;
         r_overflow  <= '0;
         r_lz        <= '0;
         r_valid     <= 1'b0;
      end else if (w_load) begin
         r_snap <= io_bus.values_in;
         r_bin  <= io_bus.values_in[W_IN-1:0];
         r_bcd  <= '0;
         r_bit  <= '0;
         r_ch   <= '0;
         r_ovf  <= 1'b0;
      end else begin
         case (r_state)
            SD_SHIFT: begin
               r_bcd <= w_step_bcd;
               r_bin <= {r_bin[W_IN-2:0], 1'b0};
               r_ovf <= r_ovf | w_step_carry;
               r_bit <= r_bit + 1'b1;
            end
            SD_STORE: begin
               for (int c = 0; c < int'(N_CH); c++) begin
                  if (int'(r_ch) == c) begin
                     r_stage_dig[c*BCD_W +: BCD_W]   <= w_store_dig;
                     r_stage_ovf[c]                  <= r_ovf;
                     r_stage_lz[c*DIGITS +: DIGITS]  <= w_store_lz;
                  end
               end
               if (r_ch == CH_LAST) begin
                  // Publish the whole set at once, last channel taken straight from this store.
                  for (int c = 0; c < int'(N_CH); c++) begin
                     r_digits[c*BCD_W +: BCD_W] <= (int'(r_ch) == c) ? w_store_dig
                                                   : r_stage_dig[c*BCD_W +: BCD_W];
                     r_overflow[c]              <= (int'(r_ch) == c) ? r_ovf : r_stage_ovf[c];
                     r_lz[c*DIGITS +: DIGITS]   <= (int'(r_ch) == c) ? w_store_lz
                                                   : r_stage_lz[c*DIGITS +: DIGITS];
                  end
                  r_valid <= 1'b1;
               end else begin
                  r_ch  <= r_ch + 1'b1;
                  r_bin <= w_next_val;
                  r_bcd <= '0;
                  r_bit <= '0;
                  r_ovf <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign io_bus.busy       = (r_state != SD_IDLE);
   assign io_bus.done       = (r_state == SD_COMMIT);
   assign io_bus.valid      = r_valid;
   assign io_bus.digits_out = r_digits;
   assign io_bus.overflow   = r_overflow;
   assign io_bus.lz_mask    = r_lz;

endmodule

// File: tb/tb_seq_decimalizer.sv
// Directed bench: a 2-digit and a 3-digit converter (3 channels, 8-bit inputs) driven in lockstep.
module tb_seq_decimalizer;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   seq_decimalizer_if #(.N_CH(3), .W_IN(8), .DIGITS(2)) bus2 ();
   seq_decimalizer_if #(.N_CH(3), .W_IN(8), .DIGITS(3)) bus3 ();

   seq_decimalizer #(.N_CH(3), .W_IN(8), .DIGITS(2)) u_dut2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus2)
   );

   seq_decimalizer #(.N_CH(3), .W_IN(8), .DIGITS(3)) u_dut3 (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus3)
   );

   int n_cmp   = 0;
   int n_fail  = 0;
   int n_done2 = 0;

   always @(negedge clk) if (bus2.done === 1'b1) n_done2++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check2(input string tag, input logic [23:0] dig, input logic [2:0] ovf,
                         input logic [5:0] lz);
      chk({tag, "_dig2"}, 64'(bus2.digits_out), 64'(dig));
      chk({tag, "_ovf2"}, 64'(bus2.overflow), 64'(ovf));
      chk({tag, "_lz2"}, 64'(bus2.lz_mask), 64'(lz));
   endtask

   task automatic check3(input string tag, input logic [35:0] dig, input logic [2:0] ovf,
                         input logic [8:0] lz);
      chk({tag, "_dig3"}, 64'(bus3.digits_out), 64'(dig));
      chk({tag, "_ovf3"}, 64'(bus3.overflow), 64'(ovf));
      chk({tag, "_lz3"}, 64'(bus3.lz_mask), 64'(lz));
   endtask

   // Edges counted include the one that samples the request; returns in the done cycle.
   task automatic wait_done(input bit scramble, output int edges, output bit busy_drop);
      edges     = 0;
      busy_drop = 1'b0;
      do begin
         @(posedge clk);
         #1;
         edges++;
         if (bus2.busy !== 1'b1) busy_drop = 1'b1;
         if (scramble && edges == 3) begin
            bus2.values_in = '1;
            bus3.values_in = '1;
         end
      end while (bus2.done !== 1'b1 && edges < 200);
   endtask

   task automatic set_vals(input logic [23:0] v2, input logic [23:0] v3);
      bus2.values_in = v2;
      bus3.values_in = v3;
   endtask

   localparam logic [23:0] V1_2 = {8'd42, 8'd99, 8'd0};
   localparam logic [23:0] V1_3 = {8'd128, 8'd0, 8'd255};
   localparam logic [23:0] V2_2 = {8'd7, 8'd255, 8'd100};
   localparam logic [23:0] V2_3 = {8'd7, 8'd255, 8'd100};
   localparam logic [23:0] V3_2 = {8'd50, 8'd10, 8'd9};
   localparam logic [23:0] V3_3 = {8'd9, 8'd10, 8'd100};

   int e;
   bit bd;
   int d0;

   initial begin
      bus2.start = 1'b0; bus2.continuous = 1'b0; bus2.values_in = '0;
      bus3.start = 1'b0; bus3.continuous = 1'b0; bus3.values_in = '0;
      #2 rst_n = 1'b0;
      #10;
      chk("rst_busy", 64'(bus2.busy), 64'd0);
      chk("rst_done", 64'(bus2.done), 64'd0);
      chk("rst_valid", 64'(bus2.valid), 64'd0);
      check2("rst", 24'h0, 3'b000, 6'b0);
      check3("rst", 36'h0, 3'b000, 9'b0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Mixed values including 0 and 99 on the 2-digit unit, 255 and 0 on the 3-digit unit.
      @(posedge clk); #1;
      set_vals(V1_2, V1_3);
      bus2.start = 1'b1; bus3.start = 1'b1;
      wait_done(1'b0, e, bd);
      bus2.start = 1'b0; bus3.start = 1'b0;
      chk("t1_lat", 64'(e), 64'd28);
      chk("t1_busy", 64'(bd), 64'd0);
      chk("t1_done3", 64'(bus3.done), 64'd1);
      chk("t1_valid", 64'(bus2.valid), 64'd1);
      check2("t1", 24'h429900, 3'b000, 6'b000010);
      check3("t1", 36'h128000255, 3'b000, 9'b000110000);
      @(posedge clk); #1;
      chk("t1_idle", 64'(bus2.busy), 64'd0);
      chk("t1_pulse", 64'(bus2.done), 64'd0);

      // Overflow: 100 and 255 saturate on two digits; 7 has a leading zero.
      set_vals(V2_2, V2_3);
      bus2.start = 1'b1; bus3.start = 1'b1;
      wait_done(1'b0, e, bd);
      bus2.start = 1'b0; bus3.start = 1'b0;
      chk("t2_lat", 64'(e), 64'd28);
      check2("t2", 24'h079999, 3'b011, 6'b100000);
      check3("t2", 36'h007255100, 3'b000, 9'b110000000);

      // Start held through the run, inputs scrambled after the snapshot.
      @(posedge clk); #1;
      d0 = n_done2;
      set_vals(V3_2, V3_3);
      bus2.start = 1'b1; bus3.start = 1'b1;
      wait_done(1'b1, e, bd);
      bus2.start = 1'b0; bus3.start = 1'b0;
      chk("t3_lat", 64'(e), 64'd28);
      chk("t3_busy", 64'(bd), 64'd0);
      check2("t3", 24'h501009, 3'b000, 6'b000010);
      check3("t3", 36'h009010100, 3'b000, 9'b110100000);
      repeat (40) @(posedge clk);
      #1;
      chk("t3_single", 64'(n_done2 - d0), 64'd1);
      chk("t3_idle", 64'(bus2.busy), 64'd0);

      // Continuous mode: back-to-back commits, new snapshot taken at commit exit.
      set_vals(V1_2, V1_3);
      bus2.continuous = 1'b1; bus3.continuous = 1'b1;
      wait_done(1'b0, e, bd);
      chk("t4_lat1", 64'(e), 64'd28);
      check2("t4a", 24'h429900, 3'b000, 6'b000010);
      set_vals(V2_2, V2_3);
      wait_done(1'b0, e, bd);
      chk("t4_period", 64'(e), 64'd28);
      chk("t4_nogap", 64'(bd), 64'd0);
      check2("t4b", 24'h079999, 3'b011, 6'b100000);
      check3("t4b", 36'h007255100, 3'b000, 9'b110000000);
      bus2.continuous = 1'b0; bus3.continuous = 1'b0;
      d0 = n_done2;
      @(posedge clk); #1;
      chk("t4_stop", 64'(bus2.busy), 64'd0);
      repeat (35) @(posedge clk);
      #1;
      chk("t4_quiet", 64'(n_done2 - d0), 64'd1);

      // Reset mid-shift clears everything at once.
      set_vals(V3_2, V3_3);
      bus2.start = 1'b1; bus3.start = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      bus2.start = 1'b0; bus3.start = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t5_busy", 64'(bus2.busy), 64'd0);
      chk("t5_valid", 64'(bus2.valid), 64'd0);
      chk("t5_valid3", 64'(bus3.valid), 64'd0);
      check2("t5", 24'h0, 3'b000, 6'b0);
      check3("t5", 36'h0, 3'b000, 9'b0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      set_vals(V1_2, V1_3);
      bus2.start = 1'b1; bus3.start = 1'b1;
      wait_done(1'b0, e, bd);
      bus2.start = 1'b0; bus3.start = 1'b0;
      chk("t5_lat", 64'(e), 64'd28);
      chk("t5_revalid", 64'(bus2.valid), 64'd1);
      check2("t5r", 24'h429900, 3'b000, 6'b000010);
      check3("t5r", 36'h128000255, 3'b000, 9'b000110000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
